regfile_wb_ctrl: RTL

//  Write-port controller for the 32x32 register file. Shares its single write port (Rw/bus_w/regWrite)

---
 rtl/regfile_ctrl_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/regfile_wb_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared constants and state encoding for the register-file write controller
package regfile_ctrl_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam int NREGS = 32;
    localparam int CW    = $clog2(NREGS);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_INIT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin priority search from a rotating pointer
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Walk the requesters starting at ptr, wrapping, and grant the first one found
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - write-port arbiter, zero-fill sequencer and write forwarding for the register file
module regfile_wb_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int AW         = RF_AW,
    parameter int DW         = RF_DW,
    parameter int R0_DISCARD = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  hold,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdata,
    input  logic [AW-1:0]         ra_addr,
    input  logic [AW-1:0]         rb_addr,
    output logic                  fwd_a_hit,
    output logic                  fwd_b_hit
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] init_cnt_q, init_cnt_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          init_done_q, init_done_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               grant_en;
    logic [AW-1:0]      g_addr;
    logic [DW-1:0]      g_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // A pending zero-fill request pre-empts any grant in the same cycle
    assign grant_en = (state_q == ST_ARB) && !hold && !init_start;
    assign g_addr   = req_addr[arb_idx*AW +: AW];
    assign g_data   = req_data[arb_idx*DW +: DW];

    // State register; reset also aborts an in-progress fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= '0;
            init_cnt_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            init_cnt_q  <= init_cnt_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state: enter fill on init_start, leave after issuing the last register
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            ST_ARB: begin
                if (init_start) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            ST_INIT: begin
                if (init_cnt_q == CW'(NREGS - 1)) begin
                    state_d    = ST_ARB;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: grant handshake and next write-port contents; address/data hold when idle
    always_comb begin
        req_ready   = '0;
        rr_ptr_d    = rr_ptr_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        init_done_d = 1'b0;
        unique case (state_q)
            ST_ARB: begin
                if (grant_en && arb_any) begin
                    req_ready = arb_grant;
                    rr_ptr_d  = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    // r0 writes are swallowed: handshake completes, file never sees it
                    if (!((R0_DISCARD != 0) && (g_addr == '0))) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = g_addr;
                        rf_wdata_d = g_data;
                    end
                end
            end
            ST_INIT: begin
                rf_we_d     = 1'b1;
                rf_waddr_d  = AW'(init_cnt_q);
                rf_wdata_d  = '0;
                init_done_d = (init_cnt_q == CW'(NREGS - 1));
            end
            default: ;
        endcase
    end

    assign init_busy = (state_q == ST_INIT);
    assign init_done = init_done_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

    // r0 reads are hard-wired zero in the file, so never forward to them
    assign fwd_a_hit = rf_we_q && (rf_waddr_q == ra_addr) && (ra_addr != '0);
    assign fwd_b_hit = rf_we_q && (rf_waddr_q == rb_addr) && (rb_addr != '0);

endmodule
